gnrc_stream_id_packer: RTL and testbench



---
 rtl/gnrc_stream_pkg.sv | 25 ++
 rtl/gnrc_slice.sv | 57 +++++
 rtl/gnrc_stream_id_packer.sv | 151 +++++++++++++++
 tb/tb_gnrc_stream_id_packer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gnrc_stream_pkg.sv
// Shared types and helpers for the generic stream id packer.
package gnrc_stream_pkg;

  // Packer FSM: emit a header beat, then pass the payload through.
  typedef enum logic {
    HDR = 1'b0,
    PLD = 1'b1
  } state_t;

  // Widest id or sequence field the header helper accepts.
  localparam int unsigned HDR_FIELD_W = 32;

  // Place seq directly above id; bits above seq are zero.
  function automatic logic [2*HDR_FIELD_W-1:0] hdr_pack(
    input logic [HDR_FIELD_W-1:0] id,
    input logic [HDR_FIELD_W-1:0] seq,
    input int unsigned            id_w
  );
    logic [2*HDR_FIELD_W-1:0] word;
    word = {{HDR_FIELD_W{1'b0}}, seq} << id_w;
    word = word | {{HDR_FIELD_W{1'b0}}, id};
    return word;
  endfunction

endpackage

// File: rtl/gnrc_slice.sv
// Forward and backward registered pipeline slice with a skid entry.
// ready_o only depends on state, valid_o/data_o come straight from flops,
// and a full beat per cycle still flows when the sink is always ready.
module gnrc_slice #(
  parameter type DTYPE = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  DTYPE data_i,
  input  logic valid_i,
  output logic ready_o,
  output DTYPE data_o,
  output logic valid_o,
  input  logic ready_i
);

  DTYPE main_q;
  DTYPE skid_q;
  logic main_valid_q;
  logic skid_valid_q;

  assign ready_o = !skid_valid_q;
  assign data_o  = main_q;
  assign valid_o = main_valid_q;

  // Refill the output register from the skid entry first, otherwise from the
  // input; park an incoming beat in the skid entry while the output stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush_i) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!main_valid_q || ready_i) begin
      if (skid_valid_q) begin
        main_q       <= skid_q;
        main_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        main_valid_q <= valid_i;
        if (valid_i) begin
          main_q <= data_i;
        end
      end
    end else if (valid_i && !skid_valid_q) begin
      skid_q       <= data_i;
      skid_valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/gnrc_stream_id_packer.sv
// Serialises id-tagged packets onto one untagged link: every packet is
// preceded by a header beat holding {seq, id}, with a per-id sequence count
// so the receiver can recover the source and spot dropped packets.
module gnrc_stream_id_packer
  import gnrc_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_ID   = 4,
  parameter int unsigned SEQ_W  = 8,
  parameter bit          OBUF   = 1'b1,
  localparam int unsigned ID_W  = (N_ID > 1) ? $clog2(N_ID) : 1,
  parameter type         ID_T   = logic [ID_W-1:0]
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              last_i,
  input  ID_T               id_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              last_o,
  output logic              hdr_o,
  input  logic              ready_i
);

  // One slot per encodable id, so out-of-range ids on a non-power-of-two
  // N_ID still land in a real register instead of falling off the array.
  localparam int unsigned N_SLOT = 2 ** ID_W;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              hdr;
  } beat_t;

  if (DATA_W < ID_W + SEQ_W) begin : g_bad_data_w
    $error("gnrc_stream_id_packer: DATA_W must be >= ID_W + SEQ_W");
  end
  if (SEQ_W > HDR_FIELD_W || SEQ_W < 1) begin : g_bad_seq_w
    $error("gnrc_stream_id_packer: SEQ_W out of supported range");
  end

  state_t                   state_q;
  state_t                   state_d;
  ID_T                      cur_id_q;
  logic [SEQ_W-1:0]         seq_q [N_SLOT];
  logic [SEQ_W-1:0]         hdr_seq;
  logic [DATA_W+2*HDR_FIELD_W-1:0] hdr_wide;

  beat_t pre_beat;
  logic  pre_valid;
  logic  pre_ready;
  logic  hdr_accept;
  logic  last_accept;

  assign hdr_seq  = seq_q[id_i];
  assign hdr_wide = {{DATA_W{1'b0}},
                     hdr_pack(HDR_FIELD_W'(id_i), HDR_FIELD_W'(hdr_seq), ID_W)};

  // Next state and the pre-slice beat; flush blocks every handshake.
  always_comb begin
    state_d     = state_q;
    pre_beat    = '0;
    pre_valid   = 1'b0;
    ready_o     = 1'b0;
    hdr_accept  = 1'b0;
    last_accept = 1'b0;
    unique case (state_q)
      HDR: begin
        pre_valid = valid_i && !flush_i;
        if (valid_i) begin
          pre_beat.data = hdr_wide[DATA_W-1:0];
          pre_beat.hdr  = 1'b1;
        end
        hdr_accept = pre_valid && pre_ready;
        if (hdr_accept) begin
          state_d = PLD;
        end
      end
      PLD: begin
        pre_valid     = valid_i && !flush_i;
        pre_beat.data = data_i;
        pre_beat.last = last_i;
        ready_o       = pre_ready && !flush_i;
        last_accept   = pre_valid && pre_ready && last_i;
        if (last_accept) begin
          state_d = HDR;
        end
      end
      default: state_d = HDR;
    endcase
  end

  // FSM, current packet id and the per-id sequence table; seq only moves
  // when a packet completes, never when its header goes out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= HDR;
      cur_id_q <= '0;
      for (int i = 0; i < int'(N_SLOT); i++) begin
        seq_q[i] <= '0;
      end
    end else if (flush_i) begin
      state_q  <= HDR;
      cur_id_q <= '0;
      for (int i = 0; i < int'(N_SLOT); i++) begin
        seq_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (hdr_accept) begin
        cur_id_q <= id_i;
      end
      if (last_accept) begin
        seq_q[cur_id_q] <= seq_q[cur_id_q] + 1'b1;
      end
    end
  end

  if (OBUF) begin : g_obuf
    beat_t out_beat;

    gnrc_slice #(
      .DTYPE (beat_t)
    ) i_slice (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .data_i  (pre_beat),
      .valid_i (pre_valid),
      .ready_o (pre_ready),
      .data_o  (out_beat),
      .valid_o (valid_o),
      .ready_i (ready_i)
    );

    assign data_o = out_beat.data;
    assign last_o = out_beat.last;
    assign hdr_o  = out_beat.hdr;
  end else begin : g_direct
    assign pre_ready = ready_i;
    assign valid_o   = pre_valid;
    assign data_o    = pre_beat.data;
    assign last_o    = pre_beat.last;
    assign hdr_o     = pre_beat.hdr;
  end

endmodule

// File: tb/tb_gnrc_stream_id_packer.sv
// Scoreboard bench for gnrc_stream_id_packer (DATA_W=32, N_ID=4, SEQ_W=8,
// OBUF=1): stimulus pushes expected beats, a monitor pops and compares.
module tb_gnrc_stream_id_packer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [31:0] data_i;
  logic        valid_i;
  logic        last_i;
  logic [1:0]  id_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        last_o;
  logic        hdr_o;
  logic        ready_i;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        hdr;
  } exp_t;

  exp_t       exp_q[$];
  int         xfer_cyc[$];
  int         checks = 0;
  int         errors = 0;
  int         cycle = 0;
  logic [7:0] seq_model[4];
  bit         rand_ready = 1'b0;

  gnrc_stream_id_packer #(
    .DATA_W (32),
    .N_ID   (4),
    .SEQ_W  (8),
    .OBUF   (1'b1)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .id_i    (id_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .hdr_o   (hdr_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Cycle counter used to measure output spacing.
  always @(posedge clk_i) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Downstream ready: constant high or random, updated just after each edge.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: pops on every output handshake, checks stall stability and
  // that a header is never marked last.
  initial begin : monitor
    exp_t want;
    exp_t stall_beat;
    bit   stall_pend = 1'b0;
    bit   flush_seen = 1'b0;
    stall_beat = '0;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (stall_pend && !flush_seen) begin
          checkOutput("stall_valid", 64'(valid_o), 64'd1);
          checkOutput("stall_beat", 64'({data_o, last_o, hdr_o}), 64'(stall_beat));
        end
        if (valid_o) begin
          checkOutput("hdr_and_last", 64'(hdr_o && last_o), 64'd0);
        end
        if (valid_o && ready_i) begin
          xfer_cyc.push_back(cycle);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat: got 0x%0h expected none", {data_o, last_o, hdr_o});
          end else begin
            want = exp_q.pop_front();
            checkOutput("beat", 64'({data_o, last_o, hdr_o}), 64'(want));
          end
        end
        stall_pend = valid_o && !ready_i;
        stall_beat = {data_o, last_o, hdr_o};
        flush_seen = flush_i;
      end
    end
  end

  // Send one packet; expected header is either hand-computed or from the seq model.
  task automatic applyStimulus(input logic [1:0] id, input int len, input logic [31:0] base,
                               input bit alt_id, input bit use_const, input logic [31:0] hdr_const);
    exp_t e;
    int   waited;
    e.data = use_const ? hdr_const : {22'd0, seq_model[id], id};
    e.last = 1'b0;
    e.hdr  = 1'b1;
    exp_q.push_back(e);
    for (int i = 0; i < len; i++) begin
      e.data = base + 32'(i);
      e.last = (i == len - 1);
      e.hdr  = 1'b0;
      exp_q.push_back(e);
    end
    seq_model[id] = seq_model[id] + 8'd1;
    for (int i = 0; i < len; i++) begin
      valid_i = 1'b1;
      data_i  = base + 32'(i);
      last_i  = (i == len - 1);
      id_i    = (alt_id && i > 0) ? 2'd3 : id;
      waited  = 0;
      @(negedge clk_i);
      while (!ready_o && waited < 200) begin
        waited++;
        @(negedge clk_i);
      end
      if (!ready_o) begin
        checks++;
        errors++;
        $display("[TB] FAIL input_timeout: got ready_o=0 expected 1 (id %0d beat %0d)", id, i);
        valid_i = 1'b0;
        return;
      end
      @(posedge clk_i);
      #1;
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  // Wait (bounded) for the scoreboard to empty.
  task automatic waitDrain(input string name);
    int waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      waited++;
      @(negedge clk_i);
    end
    checkOutput(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Hard stop in case the whole run wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   n0;
    int   waited;
    exp_t e;
    rst_ni  = 1'b1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    data_i  = '0;
    id_i    = '0;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) seq_model[i] = 8'd0;
    #1 rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    checkOutput("reset_valid_o", 64'(valid_o), 64'd0);
    checkOutput("reset_ready_o", 64'(ready_o), 64'd0);
    checkOutput("reset_data_o", 64'(data_o), 64'd0);
    checkOutput("reset_hdr_last", 64'({hdr_o, last_o}), 64'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    $display("[TB] 3-beat packet on id 2");
    applyStimulus(2'd2, 3, 32'hA, 1'b0, 1'b1, 32'h002);
    waitDrain("drain_basic");

    $display("[TB] back-to-back single-beat packets on id 1");
    n0 = xfer_cyc.size();
    applyStimulus(2'd1, 1, 32'h100, 1'b0, 1'b1, 32'h001);
    applyStimulus(2'd1, 1, 32'h101, 1'b0, 1'b1, 32'h005);
    applyStimulus(2'd1, 1, 32'h102, 1'b0, 1'b1, 32'h009);
    waitDrain("drain_b2b");
    checkOutput("b2b_beats", 64'(xfer_cyc.size() - n0), 64'd6);
    if (xfer_cyc.size() >= n0 + 6) begin
      checkOutput("b2b_span", 64'(xfer_cyc[n0+5] - xfer_cyc[n0]), 64'd5);
    end

    $display("[TB] id_i changed mid-packet");
    applyStimulus(2'd1, 3, 32'h200, 1'b1, 1'b1, 32'h00D);
    applyStimulus(2'd3, 1, 32'h300, 1'b0, 1'b1, 32'h003);
    applyStimulus(2'd1, 1, 32'h310, 1'b0, 1'b1, 32'h011);
    waitDrain("drain_alt_id");

    $display("[TB] sequence wrap on id 0");
    for (int k = 0; k < 257; k++) begin
      applyStimulus(2'd0, 1, 32'(k), 1'b0, (k >= 255), (k == 255) ? 32'h3FC : 32'h000);
    end
    waitDrain("drain_wrap");

    $display("[TB] random lengths, ids and downstream stalls");
    rand_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      applyStimulus(2'($urandom_range(0, 3)), int'($urandom_range(1, 8)), $urandom, 1'b0, 1'b0, 32'h0);
    end
    waitDrain("drain_random");
    rand_ready = 1'b0;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;

    $display("[TB] flush during second payload beat");
    e.data = {22'd0, seq_model[2], 2'd2};
    e.last = 1'b0;
    e.hdr  = 1'b1;
    exp_q.push_back(e);
    e.data = 32'h400;
    e.hdr  = 1'b0;
    exp_q.push_back(e);
    valid_i = 1'b1;
    id_i    = 2'd2;
    data_i  = 32'h400;
    last_i  = 1'b0;
    waited  = 0;
    @(negedge clk_i);
    while (!ready_o && waited < 200) begin
      waited++;
      @(negedge clk_i);
    end
    checkOutput("flush_first_beat_ready", 64'(ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    data_i  = 32'h401;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("flush_valid_o", 64'(valid_o), 64'd0);
    checkOutput("flush_ready_o", 64'(ready_o), 64'd0);
    checkOutput("flush_queue", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 4; i++) seq_model[i] = 8'd0;
    @(posedge clk_i);
    #1;
    applyStimulus(2'd2, 2, 32'h500, 1'b0, 1'b1, 32'h002);
    applyStimulus(2'd0, 1, 32'h510, 1'b0, 1'b1, 32'h000);
    applyStimulus(2'd1, 1, 32'h520, 1'b0, 1'b1, 32'h001);
    applyStimulus(2'd3, 1, 32'h530, 1'b0, 1'b1, 32'h003);
    waitDrain("drain_post_flush");

    repeat (4) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
